lcd_byte_sequencer: RTL and testbench
=====================================

Name: lcd_byte_sequencer

Overview:
- Sits directly upstream of the single-byte I2C write master that drives the PCF8574 backpack of the 2004 character LCD.
- Accepts one HD44780 command or data byte per handshake and splits it into 4-bit-mode nibble writes.
- Each nibble produces an E-high byte followed by an E-low byte, and each byte is handed to the I2C master with a start/done handshake.
- After each transfer the block enforces the HD44780 execution delay, so the text/init controller above it only issues bytes and never counts time.

Parameters:
- SHORT_WAIT, 5000: post-transfer hold in clk cycles for normal commands/data (50 us at 100 MHz).
- LONG_WAIT, 200000: hold in cycles after clear (0x01) or return-home (0x02/0x03) commands (2 ms).
- INIT_WAIT, 500000: hold in cycles after a nibble-only transfer (5 ms, covers the 4.1 ms power-on init step).
- TIMEOUT, 4000000: cycles allowed between i2c_start and i2c_done before aborting.
- BACKLIGHT, 1: value driven on PCF8574 bit 3 in every byte.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  upstream has a byte.
- in_ready  out  1  block can accept a byte.
- in_byte  in  8  HD44780 command/data byte.
- in_rs  in  1  0 = command, 1 = data (drives RS).
- in_nibble_only  in  1  send in_byte[7:4] only (init 0x3/0x2 steps).
- i2c_start  out  1  one-cycle pulse to the I2C master.
- i2c_data  out  8  PCF8574 byte {D7..D4, BL, E, RW, RS}.
- i2c_busy  in  1  I2C master busy.
- i2c_done  in  1  one-cycle completion pulse from the I2C master.
- seq_idle  out  1  high in IDLE only.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - in_ready=1, i2c_start=0, i2c_data={4'h0,BACKLIGHT,3'b000}, seq_idle=1, err=0.
  - All counters are cleared.
- Accept: in IDLE with in_valid=1 and in_ready=1.
  - Latch byte, rs and nibble_only.
  - in_ready drops on the following cycle and stays low until the return to IDLE.
  - in_byte may change after acceptance.
- Phases: P0 = hi nibble E=1; P1 = hi nibble E=0; P2 = lo nibble E=1; P3 = lo nibble E=0.
  - nibble_only runs P0 and P1 only.
  - RW is always 0. RS is the latched rs.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE: wait until i2c_busy=0. Then set i2c_data for the current phase, pulse i2c_start for exactly 1 cycle, clear the timeout counter, and go to WAIT_DONE.
  - WAIT_DONE: i2c_data is held stable.
    - On i2c_done: if more phases remain, advance the phase and go to ISSUE; otherwise clear the hold counter and go to HOLD.
    - If TIMEOUT cycles elapse without i2c_done: pulse err and go to IDLE. The partial transfer is dropped.
  - HOLD: count to the selected wait, then go to IDLE. Wait selection:
    - INIT_WAIT if nibble_only.
    - LONG_WAIT if rs=0 and byte is 0x01, 0x02 or 0x03.
    - SHORT_WAIT otherwise.
- Timing rules:
  - i2c_start is never asserted while i2c_busy=1 or in the same cycle as i2c_done.
  - Minimum gap between consecutive starts is 2 cycles.
- Boundaries:
  - in_valid held high while busy is ignored; the byte is accepted only at the next IDLE.
  - i2c_done seen outside WAIT_DONE is ignored.
  - A hold count of 0 leaves HOLD after 1 cycle.
  - Reset asserted mid-transfer returns to IDLE immediately and discards the latched byte. The I2C master is reset by the same signal.
- Counters: a 32-bit hold counter and a 32-bit timeout counter, both saturating (no wrap).

Decomposition:
- Shared package lcd_pkg holds:
  - PCF8574 bit positions (RS=0, RW=1, EN=2, BL=3, data 7:4).
  - HD44780 command constants (CLEAR 0x01, HOME 0x02, FUNC_4BIT_2L 0x28, DISP_ON 0x0C, ENTRY_INC 0x06, DDRAM_L1 0x80, DDRAM_L2 0xC0).
  - The state encoding.
- No sub-module is needed. The two counters stay inline; a generic down-counter is optional.

Test Plan (bench uses SHORT_WAIT=10, LONG_WAIT=40, INIT_WAIT=60, TIMEOUT=100 and an I2C master model with busy for 20 cycles then a done pulse):
- Data 'H' (0x48), rs=1 -> i2c_data sequence 0x4D, 0x49, 0x8D, 0x89; exactly 4 start pulses; in_ready returns 10 hold cycles after the 4th done.
- Command 0x01, rs=0 -> sequence 0x0C, 0x08, 0x1C, 0x18; hold is 40 cycles.
- nibble_only with 0x30 -> sequence 0x3C, 0x38 only; hold is 60 cycles.
- Bytes 0x80 then 0x0C issued back-to-back with in_valid held high -> second byte accepted only after seq_idle=1; no start pulse overlaps i2c_busy.
- Model withholds done -> err pulses once 100 cycles after the start; block returns to IDLE; the next byte completes normally.
- rst driven low during P2 of 0x28 -> outputs return to reset values in the same cycle; after release in_ready=1 and no further starts occur.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: PCF8574 bit map, HD44780 command codes, sequencer states.
// Latency: none (constants and pure helper functions only).
// Backpressure: not applicable.
package lcd_pkg;

  // PCF8574 backpack bit positions
  localparam int PCF_RS    = 0;
  localparam int PCF_RW    = 1;
  localparam int PCF_EN    = 2;
  localparam int PCF_BL    = 3;
  localparam int PCF_D_LSB = 4;

  // HD44780 commands
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT     = 8'h03;  // bit 0 of return-home is don't-care
  localparam logic [7:0] CMD_FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_DDRAM_L1     = 8'h80;
  localparam logic [7:0] CMD_DDRAM_L2     = 8'hC0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } seq_state_t;

  // Assemble one PCF8574 byte; RW is always write (0).
  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rs);
    logic [7:0] b;
    b                        = '0;
    b[PCF_D_LSB +: 4]        = nib;
    b[PCF_BL]                = bl;
    b[PCF_EN]                = en;
    b[PCF_RW]                = 1'b0;
    b[PCF_RS]                = rs;
    return b;
  endfunction

  // Clear and return-home need the long execution delay.
  function automatic logic is_long_cmd(input logic [7:0] b);
    return (b == CMD_CLEAR) || (b == CMD_HOME) || (b == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_byte_sequencer.sv
// Splits one HD44780 byte into 4-bit PCF8574 writes (E high then E low per nibble) and enforces the execution delay.
// Latency: first i2c_start two clock edges after the accepting edge; in_ready returns one cycle after the selected hold.
// Backpressure: in_ready is high only in IDLE; each write waits for i2c_busy low before pulsing i2c_start.
module lcd_byte_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SHORT_WAIT = 5000,
  parameter int unsigned LONG_WAIT  = 200000,
  parameter int unsigned INIT_WAIT  = 500000,
  parameter int unsigned TIMEOUT    = 4000000,
  parameter bit          BACKLIGHT  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       in_rs,
  input  logic       in_nibble_only,
  output logic       i2c_start,
  output logic [7:0] i2c_data,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  output logic       seq_idle,
  output logic       err
);

  seq_state_t  state_q, state_d;

  logic [7:0]  byte_q;
  logic        rs_q;
  logic        nib_q;
  logic [1:0]  phase_q;   // 0: hi E=1, 1: hi E=0, 2: lo E=1, 3: lo E=0
  logic [7:0]  data_q;
  logic        start_q;
  logic        err_q;
  logic [31:0] hold_cnt;
  logic [31:0] to_cnt;

  logic        accept;
  logic        issue;
  logic        advance;
  logic        to_hold;
  logic        abort;
  logic        last_phase;
  logic [31:0] wait_sel;
  logic [3:0]  cur_nib;

  assign in_ready  = (state_q == ST_IDLE);
  assign seq_idle  = (state_q == ST_IDLE);
  assign i2c_start = start_q;
  assign i2c_data  = data_q;
  assign err       = err_q;

  assign last_phase = nib_q ? (phase_q == 2'd1) : (phase_q == 2'd3);
  assign cur_nib    = phase_q[1] ? byte_q[3:0] : byte_q[7:4];

  // Select the post-transfer hold from the latched byte.
  always_comb begin
    wait_sel = 32'(SHORT_WAIT);
    if (nib_q) begin
      wait_sel = 32'(INIT_WAIT);
    end else if (!rs_q && is_long_cmd(byte_q)) begin
      wait_sel = 32'(LONG_WAIT);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and single-cycle control strobes; done takes priority over timeout.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    advance = 1'b0;
    to_hold = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Never start while the master is busy or still flagging a completion.
        if (!i2c_busy && !i2c_done) begin
          issue   = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i2c_done) begin
          if (last_phase) begin
            to_hold = 1'b1;
            state_d = ST_HOLD;
          end else begin
            advance = 1'b1;
            state_d = ST_ISSUE;
          end
        end else if (({1'b0, to_cnt} + 33'd1) >= 33'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // HOLD lasts max(wait_sel, 1) cycles.
        if (({1'b0, hold_cnt} + 33'd1) >= {1'b0, wait_sel}) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latch the request and step through the nibble phases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      phase_q <= 2'd0;
    end else if (accept) begin
      byte_q  <= in_byte;
      rs_q    <= in_rs;
      nib_q   <= in_nibble_only;
      phase_q <= 2'd0;
    end else if (advance) begin
      phase_q <= phase_q + 2'd1;
    end
  end

  // I2C byte, start pulse and error pulse; data only changes on issue so it is stable while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= pcf_byte(4'h0, BACKLIGHT, 1'b0, 1'b0);
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= issue;
      err_q   <= abort;
      if (issue) begin
        data_q <= pcf_byte(cur_nib, BACKLIGHT, ~phase_q[0], rs_q);
      end
    end
  end

  // Saturating timeout counter, cleared on every issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (issue) begin
      to_cnt <= '0;
    end else if (state_q == ST_WAIT_DONE && to_cnt != '1) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  // Saturating hold counter, cleared on entry to HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (to_hold) begin
      hold_cnt <= '0;
    end else if (state_q == ST_HOLD && hold_cnt != '1) begin
      hold_cnt <= hold_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Bench for lcd_byte_sequencer: table vectors, random bytes against a nibble-level model, and corner sequences.
// Latency: the I2C master model stays busy 20 cycles after each start, then pulses done.
// Backpressure: the master model can withhold done to force the timeout path.
module tb_lcd_byte_sequencer;

  localparam int SW = 10;
  localparam int LW = 40;
  localparam int IW = 60;
  localparam int TO = 100;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_rs;
  logic       in_nibble_only;
  logic       i2c_start;
  logic [7:0] i2c_data;
  logic       i2c_busy;
  logic       i2c_done;
  logic       seq_idle;
  logic       err;

  lcd_byte_sequencer #(
    .SHORT_WAIT(SW), .LONG_WAIT(LW), .INIT_WAIT(IW), .TIMEOUT(TO), .BACKLIGHT(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_rs(in_rs),
    .in_nibble_only(in_nibble_only),
    .i2c_start(i2c_start), .i2c_data(i2c_data), .i2c_busy(i2c_busy), .i2c_done(i2c_done),
    .seq_idle(seq_idle), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- I2C master model and protocol monitor ----------------
  logic [7:0] cap_q[$];
  int n_starts      = 0;
  int n_errs        = 0;
  int last_start_cyc = -100;
  int last_done_cyc  = 0;
  int overlap_viol  = 0;
  int stab_viol     = 0;
  int stray_ack     = 0;
  int stray_req     = 0;
  bit withhold      = 1'b0;

  initial begin
    int busy_cnt;
    busy_cnt = 0;
    i2c_busy = 1'b0;
    i2c_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        i2c_busy = 1'b0;
        i2c_done = 1'b0;
        busy_cnt = 0;
      end else begin
        if (i2c_start) begin
          if (i2c_busy || i2c_done) overlap_viol++;
          if (cyc - last_start_cyc < 2) overlap_viol++;
          n_starts++;
          last_start_cyc = cyc;
          cap_q.push_back(i2c_data);
        end
        if (err) n_errs++;
        i2c_done = 1'b0;
        if (i2c_start) begin
          i2c_busy = 1'b1;
          busy_cnt = 20;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            i2c_busy = 1'b0;
            if (!withhold) begin
              i2c_done = 1'b1;
              last_done_cyc = cyc;
              if (cap_q.size() > 0 && i2c_data !== cap_q[$]) stab_viol++;
            end
          end
        end else if (stray_req != stray_ack) begin
          i2c_done  = 1'b1;
          stray_ack = stray_req;
        end
      end
    end
  end

  // ---------------- Reference model ----------------
  logic [7:0] exp_q[$];
  int         exp_hold;

  // Each nibble n becomes n*16 + BL(8) + E(4) + rs, then n*16 + BL + rs.
  task automatic ref_model(input logic [7:0] b, input logic rs, input logic nib);
    int hi, lo, r;
    hi = int'(b) / 16;
    lo = int'(b) % 16;
    r  = rs ? 1 : 0;
    exp_q.delete();
    exp_q.push_back(8'(hi * 16 + 8 + 4 + r));
    exp_q.push_back(8'(hi * 16 + 8 + r));
    if (!nib) begin
      exp_q.push_back(8'(lo * 16 + 8 + 4 + r));
      exp_q.push_back(8'(lo * 16 + 8 + r));
    end
    if (nib) exp_hold = IW;
    else if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) exp_hold = LW;
    else exp_hold = SW;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One full transfer compared against exp_q / exp_hold.
  task automatic run_txn(input string name, input logic [7:0] b, input logic rs, input logic nib);
    int t, base, sbase, idle_cyc;
    logic [31:0] act;
    wait_ready(name);
    base  = cap_q.size();
    sbase = n_starts;
    in_valid = 1'b1; in_byte = b; in_rs = rs; in_nibble_only = nib;
    @(negedge clk);
    in_valid = 1'b0;
    in_byte = 8'($urandom); in_rs = 1'($urandom); in_nibble_only = 1'($urandom);
    chk({name, "_ready_drop"}, 32'(in_ready), 32'd0);
    t = 0;
    while (!seq_idle && t < 3000) begin @(negedge clk); t++; end
    idle_cyc = cyc;
    chk({name, "_idle"}, 32'(seq_idle), 32'd1);
    chk({name, "_starts"}, 32'(n_starts - sbase), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (base + i < cap_q.size()) ? 32'(cap_q[base + i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", name, i), act, 32'(exp_q[i]));
    end
    chk({name, "_hold"}, 32'(idle_cyc - last_done_cyc - 1), 32'(exp_hold));
  endtask

  // ---------------- Directed table ----------------
  typedef struct {
    string       name;
    logic [7:0]  b;
    logic        rs;
    logic        nib;
    int          n;
    logic [31:0] d;     // expected bytes, first in [31:24]
    int          hold;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t, sbase, base;
    logic [7:0] eq[$];
    logic [31:0] act;

    in_valid = 1'b0; in_byte = 8'h00; in_rs = 1'b0; in_nibble_only = 1'b0;
    rst = 1'b0;

    tbl[0] = '{"data_H",   8'h48, 1'b1, 1'b0, 4, 32'h4D498D89, SW};
    tbl[1] = '{"clear",    8'h01, 1'b0, 1'b0, 4, 32'h0C081C18, LW};
    tbl[2] = '{"init30",   8'h30, 1'b0, 1'b1, 2, 32'h3C380000, IW};
    tbl[3] = '{"home02",   8'h02, 1'b0, 1'b0, 4, 32'h0C082C28, LW};
    tbl[4] = '{"data03",   8'h03, 1'b1, 1'b0, 4, 32'h0D093D39, SW};
    tbl[5] = '{"func28",   8'h28, 1'b0, 1'b0, 4, 32'h2C288C88, SW};
    tbl[6] = '{"home03",   8'h03, 1'b0, 1'b0, 4, 32'h0C083C38, LW};
    tbl[7] = '{"init20",   8'h20, 1'b0, 1'b1, 2, 32'h2C280000, IW};

    // Reset values
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_i2c_start", 32'(i2c_start), 32'd0);
    chk("rst_i2c_data",  32'(i2c_data),  32'h08);
    chk("rst_seq_idle",  32'(seq_idle),  32'd1);
    chk("rst_err",       32'(err),       32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      exp_q.delete();
      for (int i = 0; i < tbl[k].n; i++) exp_q.push_back(tbl[k].d[31 - 8 * i -: 8]);
      exp_hold = tbl[k].hold;
      run_txn(tbl[k].name, tbl[k].b, tbl[k].rs, tbl[k].nib);
    end

    // Random bytes against the reference model
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic rs, nib;
      b   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      rs  = 1'($urandom);
      nib = ($urandom_range(0, 3) == 0);
      ref_model(b, rs, nib);
      run_txn($sformatf("rnd%0d", k), b, rs, nib);
    end

    // Stray done while idle must be ignored
    wait_ready("stray");
    sbase = n_starts;
    stray_req++;
    repeat (6) @(negedge clk);
    chk("stray_idle",   32'(seq_idle), 32'd1);
    chk("stray_starts", 32'(n_starts - sbase), 32'd0);

    // Back-to-back with in_valid held high: second byte only at the next IDLE
    wait_ready("b2b");
    base = cap_q.size();
    sbase = n_starts;
    in_valid = 1'b1; in_byte = 8'h80; in_rs = 1'b0; in_nibble_only = 1'b0;
    @(negedge clk);
    in_byte = 8'h0C;
    t = 0;
    while (!seq_idle && t < 3000) begin @(negedge clk); t++; end
    chk("b2b_first_idle",   32'(seq_idle), 32'd1);
    chk("b2b_first_starts", 32'(n_starts - sbase), 32'd4);
    @(negedge clk);
    chk("b2b_second_accept", 32'(seq_idle), 32'd0);
    in_valid = 1'b0;
    t = 0;
    while (!seq_idle && t < 3000) begin @(negedge clk); t++; end
    chk("b2b_second_idle", 32'(seq_idle), 32'd1);
    ref_model(8'h80, 1'b0, 1'b0);
    eq = exp_q;
    ref_model(8'h0C, 1'b0, 1'b0);
    foreach (exp_q[i]) eq.push_back(exp_q[i]);
    chk("b2b_starts", 32'(n_starts - sbase), 32'd8);
    for (int i = 0; i < 8; i++) begin
      act = (base + i < cap_q.size()) ? 32'(cap_q[base + i]) : 32'hFFFF_FFFF;
      chk($sformatf("b2b_byte%0d", i), act, 32'(eq[i]));
    end

    // Timeout: master never completes
    wait_ready("to");
    withhold = 1'b1;
    sbase = n_starts;
    in_valid = 1'b1; in_byte = 8'h41; in_rs = 1'b1; in_nibble_only = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!err && t < 400) begin @(negedge clk); t++; end
    chk("to_err_seen",    32'(err), 32'd1);
    chk("to_err_latency", 32'(cyc - last_start_cyc), 32'(TO));
    chk("to_idle",        32'(seq_idle), 32'd1);
    @(negedge clk);
    chk("to_err_width",   32'(err), 32'd0);
    chk("to_starts",      32'(n_starts - sbase), 32'd1);
    withhold = 1'b0;
    ref_model(8'h41, 1'b1, 1'b0);
    run_txn("after_to", 8'h41, 1'b1, 1'b0);

    // Reset in the middle of P2 of 0x28
    wait_ready("mid_rst");
    sbase = n_starts;
    in_valid = 1'b1; in_byte = 8'h28; in_rs = 1'b0; in_nibble_only = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (n_starts - sbase < 3 && t < 3000) begin @(negedge clk); t++; end
    chk("mid_rst_p2_reached", 32'(n_starts - sbase), 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_i2c_start", 32'(i2c_start), 32'd0);
    chk("mid_rst_i2c_data",  32'(i2c_data),  32'h08);
    chk("mid_rst_seq_idle",  32'(seq_idle),  32'd1);
    chk("mid_rst_err",       32'(err),       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sbase = n_starts;
    repeat (200) @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_starts",   32'(n_starts - sbase), 32'd0);

    // Still functional after reset
    ref_model(8'h0C, 1'b0, 1'b0);
    run_txn("post_rst_txn", 8'h0C, 1'b0, 1'b0);

    // Global protocol observations
    chk("start_overlap_or_gap", 32'(overlap_viol), 32'd0);
    chk("data_stable_to_done",  32'(stab_viol),    32'd0);
    chk("err_pulse_count",      32'(n_errs),       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
